port_group_sequencer: RTL and testbench

PORT_GROUP_SEQUENCER -- requirements
Module: port_group_sequencer

---
 rtl/port_seq_pkg.sv | 8 +
 rtl/port_group_ctrl.sv | 118 +++++++++++
 rtl/port_group_sequencer.sv | 50 +++++
 tb/tb_port_group_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/port_seq_pkg.sv
// port_seq_pkg: shared sew/state types and the elements-per-beat helper for the port group sequencer
package port_seq_pkg;
  typedef enum logic [1:0] {SEW_8 = 2'b00, SEW_16 = 2'b01, SEW_32 = 2'b10} sew_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  function automatic int unsigned elems_per_beat(input int unsigned lanes, input logic [1:0] sew);
    return sew == SEW_8 ? lanes * 4 : sew == SEW_16 ? lanes * 2 : lanes;
  endfunction
endpackage

// File: rtl/port_group_ctrl.sv
// port_group_ctrl: one write-port group (IDLE/RUN/DRAIN) with a read-to-write shift pipe; PORT_SEQ_TAIL_BE_EN adds tail byte enables
module port_group_ctrl
  import port_seq_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int ADDR_W     = 9,
  parameter int VL_W       = 12,
  parameter int PIPE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [VL_W-1:0]   vl_i,
  input  logic [1:0]        sew_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              stall_i,
  output logic              port_rdy_o,
  output logic              rd_vld_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              wr_vld_o,
  output logic [ADDR_W-1:0] wr_addr_o
`ifdef PORT_SEQ_TAIL_BE_EN
  ,
  output logic [LANES*4-1:0] wr_be_o
`endif
);
  localparam int unsigned BPB = LANES * 4;
  state_t state_q, state_d;
  logic [VL_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_hold_q, rd_hold_d, wr_hold_q, wr_hold_d;
  logic [PIPE_DEPTH-1:0] pv_q, pv_d;
  logic [ADDR_W-1:0] pa_q [PIPE_DEPTH];
  logic [ADDR_W-1:0] pa_d [PIPE_DEPTH];
  int unsigned epb, beats;
  assign epb = elems_per_beat(LANES, sew_i);
  assign beats = (32'(vl_i) + epb - 1) / epb;
  assign port_rdy_o = state_q == IDLE;
  assign rd_vld_o = state_q == RUN && !stall_i;
  assign rd_addr_o = rd_vld_o ? addr_q : rd_hold_q;
  assign wr_vld_o = pv_q[PIPE_DEPTH-1] && !stall_i;
  assign wr_addr_o = wr_vld_o ? pa_q[PIPE_DEPTH-1] : wr_hold_q;
`ifdef PORT_SEQ_TAIL_BE_EN
  localparam int TW = $clog2(BPB);
  logic [PIPE_DEPTH-1:0] pl_q, pl_d;
  logic [TW-1:0] tail_q, tail_d;
  assign wr_be_o = !wr_vld_o ? '0 : (!pl_q[PIPE_DEPTH-1] || tail_q == '0) ? '1 : ~({BPB{1'b1}} << tail_q);
`endif
  // Shift the read-to-write pipe and step the FSM only on unstalled cycles
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    addr_d = addr_q;
    rd_hold_d = rd_addr_o;
    wr_hold_d = wr_addr_o;
    pv_d = pv_q;
    pa_d = pa_q;
`ifdef PORT_SEQ_TAIL_BE_EN
    pl_d = pl_q;
    tail_d = tail_q;
`endif
    if (!stall_i) begin
      pv_d[0] = rd_vld_o;
      pa_d[0] = addr_q;
`ifdef PORT_SEQ_TAIL_BE_EN
      pl_d[0] = rem_q == VL_W'(1);
`endif
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pv_d[i] = pv_q[i-1];
        pa_d[i] = pa_q[i-1];
`ifdef PORT_SEQ_TAIL_BE_EN
        pl_d[i] = pl_q[i-1];
`endif
      end
      if (state_q == IDLE && start_i) begin
        state_d = vl_i == '0 ? DRAIN : RUN;
        rem_d = VL_W'(beats);
        addr_d = base_addr_i;
`ifdef PORT_SEQ_TAIL_BE_EN
        tail_d = TW'((32'(vl_i) * (BPB / epb)) % BPB);
`endif
      end else if (state_q == RUN) begin
        rem_d = rem_q - 1'b1;
        addr_d = addr_q + 1'b1;
        state_d = rem_q == VL_W'(1) ? DRAIN : RUN;
      end else if (state_q == DRAIN && pv_d == '0) begin
        state_d = IDLE;
      end
    end
  end
  // Group registers; reset drops every in-flight beat
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      rem_q <= '0;
      addr_q <= '0;
      rd_hold_q <= '0;
      wr_hold_q <= '0;
      pv_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) pa_q[i] <= '0;
`ifdef PORT_SEQ_TAIL_BE_EN
      pl_q <= '0;
      tail_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      addr_q <= addr_d;
      rd_hold_q <= rd_hold_d;
      wr_hold_q <= wr_hold_d;
      pv_q <= pv_d;
      pa_q <= pa_d;
`ifdef PORT_SEQ_TAIL_BE_EN
      pl_q <= pl_d;
      tail_q <= tail_d;
`endif
    end
  end
endmodule

// File: rtl/port_group_sequencer.sv
// port_group_sequencer: W_PORTS_NUM independent group sequencers with packed outputs; PORT_SEQ_TAIL_BE_EN adds wr_be_o
module port_group_sequencer
  import port_seq_pkg::*;
#(
  parameter int W_PORTS_NUM = 4,
  parameter int LANES       = 4,
  parameter int ADDR_W      = 9,
  parameter int VL_W        = 12,
  parameter int PIPE_DEPTH  = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [W_PORTS_NUM-1:0]        start_i,
  input  logic [VL_W-1:0]               vl_i,
  input  logic [1:0]                    sew_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  input  logic [W_PORTS_NUM-1:0]        stall_i,
  output logic [W_PORTS_NUM-1:0]        port_rdy_o,
  output logic [W_PORTS_NUM-1:0]        rd_vld_o,
  output logic [W_PORTS_NUM*ADDR_W-1:0] rd_addr_o,
  output logic [W_PORTS_NUM-1:0]        wr_vld_o,
  output logic [W_PORTS_NUM*ADDR_W-1:0] wr_addr_o
`ifdef PORT_SEQ_TAIL_BE_EN
  ,
  output logic [W_PORTS_NUM*LANES*4-1:0] wr_be_o
`endif
);
  for (genvar g = 0; g < W_PORTS_NUM; g++) begin : g_grp
    port_group_ctrl #(
      .LANES(LANES), .ADDR_W(ADDR_W), .VL_W(VL_W), .PIPE_DEPTH(PIPE_DEPTH)
    ) u_ctrl (
      .clk(clk),
      .rstn(rstn),
      .start_i(start_i[g]),
      .vl_i(vl_i),
      .sew_i(sew_i),
      .base_addr_i(base_addr_i),
      .stall_i(stall_i[g]),
      .port_rdy_o(port_rdy_o[g]),
      .rd_vld_o(rd_vld_o[g]),
      .rd_addr_o(rd_addr_o[g*ADDR_W +: ADDR_W]),
      .wr_vld_o(wr_vld_o[g]),
      .wr_addr_o(wr_addr_o[g*ADDR_W +: ADDR_W])
`ifdef PORT_SEQ_TAIL_BE_EN
      ,
      .wr_be_o(wr_be_o[g*LANES*4 +: LANES*4])
`endif
    );
  end
endmodule

// File: tb/tb_port_group_sequencer.sv
// tb_port_group_sequencer: scoreboard bench for port_group_sequencer (LANES=4, PIPE_DEPTH=3)
module tb_port_group_sequencer;
  logic clk = 0, rstn = 0;
  logic [3:0] start_i = '0, stall_i = '0;
  logic [11:0] vl_i = '0;
  logic [1:0] sew_i = '0;
  logic [8:0] base_addr_i = '0;
  logic [3:0] port_rdy_o, rd_vld_o, wr_vld_o;
  logic [35:0] rd_addr_o, wr_addr_o;
`ifdef PORT_SEQ_TAIL_BE_EN
  logic [63:0] wr_be_o;
`endif
  typedef struct {
    int g;
    logic [8:0] addr;
    int cyc;
    logic [15:0] be;
  } beat_t;
  beat_t rd_q[$], wr_q[$];
  beat_t mb;
  int n_cmp = 0, n_err = 0, cyc = 0, n_wr = 0;

  port_group_sequencer #(
    .W_PORTS_NUM(4), .LANES(4), .ADDR_W(9), .VL_W(12), .PIPE_DEPTH(3)
  ) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .vl_i(vl_i), .sew_i(sew_i),
    .base_addr_i(base_addr_i), .stall_i(stall_i), .port_rdy_o(port_rdy_o),
    .rd_vld_o(rd_vld_o), .rd_addr_o(rd_addr_o), .wr_vld_o(wr_vld_o), .wr_addr_o(wr_addr_o)
`ifdef PORT_SEQ_TAIL_BE_EN
    , .wr_be_o(wr_be_o)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit stl(input int t, input int s0, input int s1);
    return t >= s0 && t < s1;
  endfunction

  // Pop the scoreboard on every beat the DUT issues
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rd_vld_o[g]) begin
        if (rd_q.size() == 0) check("rd_extra", 1, 0);
        else begin
          mb = rd_q.pop_front();
          check("rd_grp", g, mb.g);
          check("rd_addr", rd_addr_o[g*9 +: 9], mb.addr);
          check("rd_cyc", cyc, mb.cyc);
        end
      end
      if (wr_vld_o[g]) begin
        n_wr++;
        if (wr_q.size() == 0) check("wr_extra", 1, 0);
        else begin
          mb = wr_q.pop_front();
          check("wr_grp", g, mb.g);
          check("wr_addr", wr_addr_o[g*9 +: 9], mb.addr);
          check("wr_cyc", cyc, mb.cyc);
`ifdef PORT_SEQ_TAIL_BE_EN
          check("wr_be", wr_be_o[g*16 +: 16], mb.be);
`endif
        end
      end
    end
  end

  task automatic run_op(input int g, input int vl, input int sew, input int base,
                        input int st_at, input int st_len, input bit re);
    int s, epb, nb, tail, t, w, c, exp_idle;
    logic [8:0] last_a;
    bit done;
    @(posedge clk);
    #1;
    s = cyc;
    start_i = 4'(1 << g);
    vl_i = 12'(vl);
    sew_i = 2'(sew);
    base_addr_i = 9'(base);
    epb = 16 >> sew;
    nb = (vl + epb - 1) / epb;
    tail = (vl << sew) % 16;
    t = s;
    w = s + 1;
    last_a = '0;
    for (int i = 0; i < nb; i++) begin
      t++;
      while (stl(t, s + st_at, s + st_at + st_len)) t++;
      last_a = 9'(base + i);
      rd_q.push_back('{g, last_a, t, 16'hFFFF});
      w = t;
      c = 0;
      while (c < 3) begin
        w++;
        if (!stl(w, s + st_at, s + st_at + st_len)) c++;
      end
      wr_q.push_back('{g, last_a, w, (i == nb - 1 && tail != 0) ? 16'((1 << tail) - 1) : 16'hFFFF});
    end
    exp_idle = w + 1;
    done = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(posedge clk);
      #1;
      start_i = (re && k == 2) ? 4'(1 << g) : '0;
      base_addr_i = (re && k == 2) ? 9'h100 : base_addr_i;
      stall_i[g] = stl(cyc, s + st_at, s + st_at + st_len);
      @(negedge clk);
      if (k == 1) begin
        check("rdy_busy", port_rdy_o[g], 0);
        check("rdy_others", port_rdy_o | 4'(1 << g), 4'hF);
      end else if (port_rdy_o[g]) begin
        check("idle_cyc", cyc, exp_idle);
        done = 1;
      end
    end
    stall_i = '0;
    if (!done) check("idle_timeout", 0, 1);
    check("rd_left", rd_q.size(), 0);
    check("wr_left", wr_q.size(), 0);
    if (nb > 0) begin
      check("rd_hold", rd_addr_o[g*9 +: 9], last_a);
      check("wr_hold", wr_addr_o[g*9 +: 9], last_a);
    end
  endtask

  initial begin
    int s, nw;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", port_rdy_o, 4'hF);
    check("rst_rd_vld", rd_vld_o, 0);
    check("rst_wr_vld", wr_vld_o, 0);
    check("rst_rd_addr", rd_addr_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    @(posedge clk);
    #1;
    rstn = 1;
    run_op(0, 10, 2, 'h040, 0, 0, 0);
    run_op(1, 0, 2, 'h000, 0, 0, 0);
    run_op(0, 10, 2, 'h040, 2, 2, 0);
    run_op(2, 8, 2, 'h1FF, 0, 0, 0);
    run_op(3, 33, 0, 'h010, 0, 0, 1);
    run_op(0, 20, 1, 'h0A0, 5, 1, 0);
    run_op(1, 5, 2, 'h1FE, 1, 1, 0);
    @(posedge clk);
    #1;
    s = cyc;
    start_i = 4'b0001;
    vl_i = 12'd40;
    sew_i = 2'd2;
    base_addr_i = 9'h080;
    rd_q.push_back('{0, 9'h080, s + 1, 16'hFFFF});
    rd_q.push_back('{0, 9'h081, s + 2, 16'hFFFF});
    @(posedge clk);
    #1;
    start_i = '0;
    @(posedge clk);
    #1;
    rstn = 0;
    nw = n_wr;
    @(posedge clk);
    #1;
    rstn = 1;
    @(negedge clk);
    check("abort_rdy", port_rdy_o, 4'hF);
    check("abort_rd_vld", rd_vld_o, 0);
    check("abort_wr_vld", wr_vld_o, 0);
    check("abort_rd_addr", rd_addr_o, 0);
    check("abort_wr_addr", wr_addr_o, 0);
    repeat (10) @(negedge clk);
    check("abort_no_wr", n_wr, nw);
    check("abort_rd_left", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
